// File: rtl/ap3216c_i2c_master_if.sv
// Command interface between the sensor sequencer (master modport) and the
// I2C engine (slave modport). bit_ctrl exists only when I2C_ADDR16_EN is defined.
interface ap3216c_i2c_master_if;
  logic        i2c_exec;
  logic        read1_write0;
  logic [15:0] iic_inner_reg_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;
  logic        busy;
`ifdef I2C_ADDR16_EN
  logic        bit_ctrl;

  modport master (output i2c_exec, read1_write0, iic_inner_reg_addr, i2c_data_w, bit_ctrl,
                  input  i2c_data_r, i2c_done, i2c_ack, busy);
  modport slave  (input  i2c_exec, read1_write0, iic_inner_reg_addr, i2c_data_w, bit_ctrl,
                  output i2c_data_r, i2c_done, i2c_ack, busy);
`else
  modport master (output i2c_exec, read1_write0, iic_inner_reg_addr, i2c_data_w,
                  input  i2c_data_r, i2c_done, i2c_ack, busy);
  modport slave  (input  i2c_exec, read1_write0, iic_inner_reg_addr, i2c_data_w,
                  output i2c_data_r, i2c_done, i2c_ack, busy);
`endif
endinterface

// File: rtl/ap3216c_i2c_master.sv
// Single-register read/write I2C master for the AP3216C sensor.
// Define I2C_ADDR16_EN to add bit_ctrl and an optional high register-address byte.
module ap3216c_i2c_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1E,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 250_000
) (
  input  logic                    clk,
  input  logic                    rst,
  ap3216c_i2c_master_if.slave     cmd,
  output logic                    scl,
  output logic                    sda_o,
  output logic                    sda_oe,
  input  logic                    sda_i
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_W,
    S_RESTART, S_DEV_R, S_DATA_R, S_STOP, S_DONE
  } state_t;

  state_t          state, state_nxt, reg_first;
  logic [QW-1:0]   qcnt;
  logic [1:0]      quarter;
  logic [3:0]      bit_idx;
  logic            tick, period_end, byte_end, sample_pt, ack_bit;
  logic            is_byte, slave_acks;
  logic            rw_q;
  logic [7:0]      data_w_q, rx_q, tx_byte;
  logic            scl_nxt, drv_nxt;

`ifdef I2C_ADDR16_EN
  logic [15:0]     addr_q;
  logic            bit_ctrl_q;
  assign reg_first = bit_ctrl_q ? S_REG_HI : S_REG_LO;
`else
  logic [7:0]      addr_q;
  logic            unused_addr_hi;
  assign unused_addr_hi = ^cmd.iic_inner_reg_addr[15:8];
  assign reg_first      = S_REG_LO;
`endif

  assign tick       = (qcnt == Q_LAST);
  assign period_end = tick && (quarter == 2'd3);
  assign ack_bit    = (bit_idx == 4'd8);
  assign byte_end   = period_end && ack_bit;
  assign sample_pt  = (qcnt == '0) && (quarter == 2'd2);
  assign is_byte    = state inside {S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_W, S_DEV_R, S_DATA_R};
  assign slave_acks = is_byte && (state != S_DATA_R);
  assign sda_o      = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (cmd.i2c_exec) state_nxt = S_START;
      S_START:   if (period_end)   state_nxt = S_DEV_W;
      S_DEV_W:   if (byte_end)     state_nxt = cmd.i2c_ack ? S_STOP : reg_first;
      S_REG_HI:  if (byte_end)     state_nxt = cmd.i2c_ack ? S_STOP : S_REG_LO;
      S_REG_LO:  if (byte_end)     state_nxt = cmd.i2c_ack ? S_STOP :
                                               (rw_q ? S_RESTART : S_DATA_W);
      S_DATA_W:  if (byte_end)     state_nxt = S_STOP;
      S_RESTART: if (period_end)   state_nxt = S_DEV_R;
      S_DEV_R:   if (byte_end)     state_nxt = cmd.i2c_ack ? S_STOP : S_DATA_R;
      S_DATA_R:  if (byte_end)     state_nxt = S_STOP;
      S_STOP:    if (period_end)   state_nxt = S_DONE;
      S_DONE:                      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Quarter/bit timing; bit_idx restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state == S_DONE) begin
      qcnt    <= '0;
      quarter <= 2'd0;
      bit_idx <= 4'd0;
    end else begin
      qcnt <= tick ? '0 : qcnt + 1'b1;
      if (tick) quarter <= quarter + 2'd1;
      if (state_nxt != state) bit_idx <= 4'd0;
      else if (period_end)    bit_idx <= bit_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q           <= 1'b0;
      addr_q         <= '0;
      data_w_q       <= 8'h00;
      rx_q           <= 8'h00;
      cmd.i2c_data_r <= 8'h00;
      cmd.i2c_ack    <= 1'b0;
`ifdef I2C_ADDR16_EN
      bit_ctrl_q     <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && cmd.i2c_exec) begin
        rw_q        <= cmd.read1_write0;
        addr_q      <= cmd.iic_inner_reg_addr[$bits(addr_q)-1:0];
        data_w_q    <= cmd.i2c_data_w;
        cmd.i2c_ack <= 1'b0;
`ifdef I2C_ADDR16_EN
        bit_ctrl_q  <= cmd.bit_ctrl;
`endif
      end
      if (slave_acks && ack_bit && sample_pt && sda_i) cmd.i2c_ack <= 1'b1;
      if (state == S_DATA_R && !ack_bit && sample_pt) rx_q <= {rx_q[6:0], sda_i};
      if (state == S_DATA_R && byte_end) cmd.i2c_data_r <= rx_q;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_DEV_W:  tx_byte = {SLAVE_ADDR, 1'b0};
`ifdef I2C_ADDR16_EN
      S_REG_HI: tx_byte = addr_q[15:8];
`endif
      S_REG_LO: tx_byte = addr_q[7:0];
      S_DATA_W: tx_byte = data_w_q;
      S_DEV_R:  tx_byte = {SLAVE_ADDR, 1'b1};
      default:  tx_byte = 8'h00;
    endcase
  end

  // Bus waveform per quarter; the 9th bit of every byte leaves SDA released.
  always_comb begin
    scl_nxt      = 1'b1;
    drv_nxt      = 1'b0;
    cmd.i2c_done = (state == S_DONE);
    cmd.busy     = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_START:   drv_nxt = quarter[1];
      S_RESTART: begin
        scl_nxt = (quarter != 2'd0);
        drv_nxt = quarter[1];
      end
      S_STOP: begin
        scl_nxt = (quarter != 2'd0);
        drv_nxt = !quarter[1];
      end
      S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_W, S_DEV_R: begin
        scl_nxt = (quarter != 2'd0);
        drv_nxt = !ack_bit && !tx_byte[~bit_idx[2:0]];
      end
      S_DATA_R:  scl_nxt = (quarter != 2'd0);
      default:   ;
    endcase
  end

  // Pins are registered so SCL/SDA never glitch on decode transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl    <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      scl    <= scl_nxt;
      sda_oe <= drv_nxt;
    end
  end

endmodule

// File: tb/tb_ap3216c_i2c_master.sv
// Self-checking bench: bus-level slave model plus a transaction-level
// expectation of bytes, latency, ACK flag and read data.
module tb_ap3216c_i2c_master;

  localparam int DIV       = 4;
  localparam int QP        = 4 * DIV;
  localparam int START_TOK = 256;
  localparam int STOP_TOK  = 512;
`ifdef I2C_ADDR16_EN
  localparam bit ADDR16 = 1'b1;
`else
  localparam bit ADDR16 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl, sda_o, sda_oe;
  logic slv_low = 1'b0;
  wire  sda_i = ~(sda_oe | slv_low);

  ap3216c_i2c_master_if bus();

  ap3216c_i2c_master #(
    .SLAVE_ADDR(7'h1E), .CLK_FREQ(4_000_000), .I2C_FREQ(250_000)
  ) dut (
    .clk(clk), .rst(rst), .cmd(bus.slave),
    .scl(scl), .sda_o(sda_o), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         nack_idx = -1;
  logic [7:0] slave_rdata = 8'h00;
  logic       master_ack_bit;
  int         log_q[$];
  logic [7:0] exp_data_r = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-level slave: logs START/STOP and bytes, ACKs unless told to NACK,
  // and transmits slave_rdata after a read address.
  initial begin : slave_model
    logic prev_scl, prev_sda, line;
    int bit_cnt, xfer_idx, byte_idx;
    logic [7:0] shft;
    bit tx_mode, go_tx;
    prev_scl = 1'b1; prev_sda = 1'b1; bit_cnt = 0; xfer_idx = 0; byte_idx = 0;
    shft = 8'h00; tx_mode = 1'b0; go_tx = 1'b0;
    forever begin
      @(negedge clk);
      line = ~(sda_oe | slv_low);
      if (rst) begin
        bit_cnt = 0; xfer_idx = 0; byte_idx = 0; tx_mode = 1'b0; go_tx = 1'b0;
        slv_low = 1'b0;
      end else if (scl && prev_scl && prev_sda && !line) begin
        log_q.push_back(START_TOK);
        bit_cnt = 0; byte_idx = 0; tx_mode = 1'b0; go_tx = 1'b0; slv_low = 1'b0;
      end else if (scl && prev_scl && !prev_sda && line) begin
        log_q.push_back(STOP_TOK);
        bit_cnt = 0; xfer_idx = 0; tx_mode = 1'b0; slv_low = 1'b0;
      end else if (scl && !prev_scl) begin
        if (bit_cnt < 8) begin
          shft = {shft[6:0], line};
          bit_cnt++;
        end else if (bit_cnt == 8) begin
          master_ack_bit = line;
          bit_cnt = 9;
        end
      end else if (!scl && prev_scl) begin
        if (bit_cnt == 8) begin
          log_q.push_back(int'(shft));
          if (tx_mode) slv_low = 1'b0;
          else         slv_low = (xfer_idx != nack_idx);
          if (!tx_mode && byte_idx == 0 && shft[0]) go_tx = 1'b1;
          xfer_idx++;
        end else if (bit_cnt == 9) begin
          slv_low = 1'b0; bit_cnt = 0; byte_idx++;
          if (tx_mode) tx_mode = 1'b0;
          else if (go_tx) begin
            tx_mode = 1'b1; go_tx = 1'b0;
            slv_low = ~slave_rdata[7];
          end
        end else if (tx_mode && bit_cnt >= 1 && bit_cnt < 8) begin
          slv_low = ~slave_rdata[7-bit_cnt];
        end
      end
      prev_scl = scl;
      prev_sda = ~(sda_oe | slv_low);
    end
  end

  // Issue one command from an IDLE cycle and check the whole transaction.
  task automatic run_cmd(input logic rw, input logic [15:0] ra, input logic [7:0] wd,
                         input logic bc, input int nk, input logic [7:0] rd, input bit inject);
    int sent[$];
    int exp_q[$];
    int periods, lat, cyc, dones;
    bit nacked;
    sent.push_back(8'h3C);
    if (ADDR16 && bc) sent.push_back(int'(ra[15:8]));
    sent.push_back(int'(ra[7:0]));
    sent.push_back(rw ? 8'h3D : int'(wd));
    nacked = (nk >= 0) && (nk < sent.size());
    exp_q.push_back(START_TOK);
    periods = 2;
    for (int i = 0; i < sent.size(); i++) begin
      if (rw && i == sent.size() - 1) begin
        exp_q.push_back(START_TOK);
        periods++;
      end
      exp_q.push_back(sent[i]);
      periods += 9;
      if (nacked && i == nk) break;
    end
    if (rw && !nacked) begin
      exp_q.push_back(int'(rd));
      periods += 9;
      exp_data_r = rd;
    end
    exp_q.push_back(STOP_TOK);
    lat = periods * QP;

    nack_idx = nk; slave_rdata = rd; log_q.delete();
    bus.i2c_exec = 1'b1; bus.read1_write0 = rw;
    bus.iic_inner_reg_addr = ra; bus.i2c_data_w = wd;
`ifdef I2C_ADDR16_EN
    bus.bit_ctrl = bc;
`endif
    @(posedge clk); #1;
    bus.i2c_exec = 1'b0; bus.read1_write0 = ~rw;
    bus.iic_inner_reg_addr = 16'($urandom); bus.i2c_data_w = 8'($urandom);
`ifdef I2C_ADDR16_EN
    bus.bit_ctrl = ~bc;
`endif
    check("busy_after_exec", bus.busy, 1'b1);
    check("ack_cleared", bus.i2c_ack, 1'b0);
    cyc = 0; dones = 0;
    while (cyc < lat + 40 && dones == 0) begin
      @(posedge clk); cyc++; #1;
      if (bus.i2c_done) dones++;
      if (inject && cyc == 40) begin
        bus.i2c_exec = 1'b1;
        bus.read1_write0 = ~rw;
      end
      if (inject && cyc == 41) bus.i2c_exec = 1'b0;
    end
    check("done_latency", cyc, lat);
    check("ack_flag", bus.i2c_ack, nacked);
    check("data_r", bus.i2c_data_r, exp_data_r);
    check("byte_log_len", log_q.size(), exp_q.size());
    if (log_q.size() == exp_q.size())
      foreach (exp_q[i]) check($sformatf("byte_log[%0d]", i), log_q[i], exp_q[i]);
    if (rw && !nacked) check("master_nack_on_data", master_ack_bit, 1'b1);
    @(posedge clk); #1;
    check("done_one_cycle", bus.i2c_done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
    if (inject) begin
      dones = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (bus.i2c_done || bus.busy) dones++;
      end
      check("busy_exec_ignored", dones, 0);
    end
    if (cyc >= lat + 40) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc, dones, nk;
    logic rw, bc;
    logic [15:0] ra;
    bus.i2c_exec = 1'b0; bus.read1_write0 = 1'b0;
    bus.iic_inner_reg_addr = 16'h0000; bus.i2c_data_w = 8'h00;
`ifdef I2C_ADDR16_EN
    bus.bit_ctrl = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl, 1'b1);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sda_o", sda_o, 1'b0);
    check("rst_done", bus.i2c_done, 1'b0);
    check("rst_ack", bus.i2c_ack, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_data_r", bus.i2c_data_r, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(1'b0, 16'h0000, 8'h03, 1'b0, -1, 8'h00, 1'b0);
    run_cmd(1'b1, 16'h000E, 8'h00, 1'b0, -1, 8'hA5, 1'b0);
    run_cmd(1'b1, 16'h000E, 8'h00, 1'b0, 0, 8'h5A, 1'b0);
    run_cmd(1'b0, 16'h0010, 8'h77, 1'b0, -1, 8'h00, 1'b1);
    run_cmd(1'b0, 16'h0001, 8'hC3, 1'b0, 2, 8'h00, 1'b0);

    // Reset in the middle of the data byte of a write.
    nack_idx = -1;
    bus.i2c_exec = 1'b1; bus.read1_write0 = 1'b0;
    bus.iic_inner_reg_addr = 16'h0020; bus.i2c_data_w = 8'h81;
`ifdef I2C_ADDR16_EN
    bus.bit_ctrl = 1'b0;
`endif
    @(posedge clk); #1; bus.i2c_exec = 1'b0;
    dones = 0;
    for (cyc = 0; cyc < 19 * QP + 40; cyc++) begin
      @(posedge clk); #1;
      if (bus.i2c_done) dones++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.i2c_done, 1'b0);
    rst = 1'b0;
    exp_data_r = 8'h00;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.i2c_done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_cmd(1'b1, 16'h000C, 8'h00, 1'b0, -1, 8'h3E, 1'b0);

    run_cmd(1'b0, 16'h1234, 8'h55, 1'b1, -1, 8'h00, 1'b0);
    run_cmd(1'b1, 16'hBEEF, 8'h00, 1'b1, -1, 8'h96, 1'b0);

    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom);
      bc = 1'($urandom);
      ra = 16'($urandom);
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd(rw, ra, 8'($urandom), bc, nk, 8'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
